// File: rtl/exe_stage_reduced_if.sv
// Issue/result bundle between register-read, the reduced execute stage,
// and the fetch/writeback consumers of its results.
interface exe_stage_reduced_if #(
    parameter int unsigned XLEN = 64
);
    logic            kill_i;
    logic            valid_i;
    logic [1:0]      unit_i;
    logic [2:0]      op_i;
    logic            use_imm_i;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic            pred_taken_i;
    logic [XLEN-1:0] pred_addr_i;

    logic            arith_valid_o;
    logic [XLEN-1:0] arith_result_o;
    logic [XLEN-1:0] arith_result_pc_o;
    logic            muldiv_valid_o;
    logic [XLEN-1:0] muldiv_result_o;
    logic            stall_o;
    logic            correct_branch_pred_o;
    logic            branch_taken_o;
    logic [XLEN-1:0] branch_target_o;
    logic [XLEN-1:0] branch_pc_o;

    modport master (
        output kill_i, valid_i, unit_i, op_i, use_imm_i, imm_i, pc_i,
               rs1_data_i, rs2_data_i, pred_taken_i, pred_addr_i,
        input  arith_valid_o, arith_result_o, arith_result_pc_o,
               muldiv_valid_o, muldiv_result_o, stall_o,
               correct_branch_pred_o, branch_taken_o, branch_target_o,
               branch_pc_o
    );

    modport slave (
        input  kill_i, valid_i, unit_i, op_i, use_imm_i, imm_i, pc_i,
               rs1_data_i, rs2_data_i, pred_taken_i, pred_addr_i,
        output arith_valid_o, arith_result_o, arith_result_pc_o,
               muldiv_valid_o, muldiv_result_o, stall_o,
               correct_branch_pred_o, branch_taken_o, branch_target_o,
               branch_pc_o
    );
endinterface

// File: rtl/exe_stage_reduced.sv
// Reduced integer execute stage: zero-latency ADD/SUB/JAL/JALR plus an
// iterative MUL/DIV unit that stalls register-read while it is busy.
module exe_stage_reduced #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned DIV_CYCLES = 64,
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    exe_stage_reduced_if.slave bus
);
    localparam logic [1:0] UNIT_ALU = 2'd0;
    localparam logic [1:0] UNIT_MUL = 2'd1;
    localparam logic [1:0] UNIT_DIV = 2'd2;
    localparam logic [1:0] UNIT_BR  = 2'd3;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_JAL  = 3'd4;
    localparam logic [2:0] OP_JALR = 3'd5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned CNT_W    = $clog2(DIV_CYCLES + 1);
    localparam int unsigned MUL_BUSY = (MUL_CYCLES > 1) ? MUL_CYCLES - 1 : 1;
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_BUSY);

    // ---------------- arithmetic / jump path ----------------
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] jalr_target;
    logic [XLEN-1:0] arith_result;
    logic            is_jal;
    logic            is_jalr;

    always_comb begin
        op2         = bus.use_imm_i ? bus.imm_i : bus.rs2_data_i;
        jalr_sum    = bus.rs1_data_i + bus.imm_i;
        jalr_target = {jalr_sum[XLEN-1:1], 1'b0};
        is_jal      = (bus.op_i == OP_JAL);
        is_jalr     = (bus.op_i == OP_JALR);
        case (bus.op_i)
            OP_ADD:           arith_result = bus.rs1_data_i + op2;
            OP_SUB:           arith_result = bus.rs1_data_i - op2;
            OP_JAL, OP_JALR:  arith_result = bus.pc_i + XLEN'(4);
            default:          arith_result = '0;
        endcase
    end

    assign bus.arith_valid_o     = bus.valid_i && !bus.kill_i &&
                                   (bus.unit_i == UNIT_ALU || bus.unit_i == UNIT_BR);
    assign bus.arith_result_o    = arith_result;
    assign bus.arith_result_pc_o = is_jalr ? jalr_target : '0;

    // JAL targets are resolved at decode; the stage only reports pc+imm for tracing
    assign bus.branch_taken_o        = is_jal || is_jalr;
    assign bus.branch_target_o       = is_jalr ? jalr_target :
                                       is_jal  ? bus.pc_i + bus.imm_i : '0;
    assign bus.correct_branch_pred_o = is_jalr ?
        (bus.pred_taken_i && (bus.pred_addr_i == jalr_target)) : 1'b1;
    assign bus.branch_pc_o           = bus.pc_i;

    // ---------------- mul/div unit ----------------
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  a_q, a_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             dz_q, dz_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic             md_req;
    logic [XLEN:0]    rem_shift;
    logic [XLEN:0]    rem_diff;
    logic [XLEN-1:0]  quo_step;
    logic [XLEN-1:0]  rem_step;
    logic [XLEN-1:0]  quo_fixed;
    logic [XLEN-1:0]  rs1_abs;
    logic [XLEN-1:0]  rs2_abs;

    assign md_req = bus.valid_i && (bus.unit_i == UNIT_MUL || bus.unit_i == UNIT_DIV);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        result_d = result_q;

        // One restoring step: a_q shifts the dividend out and the quotient in
        rem_shift = {rem_q, a_q[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, b_q};
        quo_step  = {a_q[XLEN-2:0], ~rem_diff[XLEN]};
        rem_step  = rem_diff[XLEN] ? rem_shift[XLEN-1:0] : rem_diff[XLEN-1:0];
        quo_fixed = neg_q ? -quo_step : quo_step;

        rs1_abs = bus.rs1_data_i[XLEN-1] ? -bus.rs1_data_i : bus.rs1_data_i;
        rs2_abs = bus.rs2_data_i[XLEN-1] ? -bus.rs2_data_i : bus.rs2_data_i;

        case (state_q)
            ST_IDLE: begin
                if (md_req && !bus.kill_i) begin
                    state_d  = ST_BUSY;
                    rem_d    = '0;
                    is_div_d = (bus.unit_i == UNIT_DIV);
                    if (bus.unit_i == UNIT_DIV) begin
                        cnt_d = DIV_LOAD;
                        a_d   = rs1_abs;
                        b_d   = rs2_abs;
                        neg_d = bus.rs1_data_i[XLEN-1] ^ bus.rs2_data_i[XLEN-1];
                        dz_d  = (bus.rs2_data_i == '0);
                    end else begin
                        cnt_d = MUL_LOAD;
                        a_d   = bus.rs1_data_i;
                        b_d   = bus.rs2_data_i;
                        neg_d = 1'b0;
                        dz_d  = 1'b0;
                    end
                end
            end
            ST_BUSY: begin
                if (is_div_q) begin
                    a_d   = quo_step;
                    rem_d = rem_step;
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    if (is_div_q) result_d = dz_q ? '1 : quo_fixed;
                    else          result_d = a_q * b_q;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (bus.kill_i) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            result_q <= result_d;
        end
    end

    assign bus.muldiv_valid_o  = (state_q == ST_DONE) && !bus.kill_i;
    assign bus.muldiv_result_o = result_q;
    assign bus.stall_o         = !bus.kill_i &&
                                 ((md_req && state_q != ST_DONE) || state_q == ST_BUSY);
endmodule

// File: tb/tb_exe_stage_reduced.sv
// Directed bench for exe_stage_reduced: ALU/jump results, mul/div latency,
// divide corner cases and kill behaviour.
module tb_exe_stage_reduced;
    localparam int unsigned XLEN = 64;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    exe_stage_reduced_if #(.XLEN(XLEN)) bus ();

    exe_stage_reduced #(
        .XLEN       (XLEN),
        .DIV_CYCLES (64),
        .MUL_CYCLES (2)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] unit, input logic [2:0] op, input logic use_imm,
                         input logic [63:0] imm, input logic [63:0] pc,
                         input logic [63:0] rs1, input logic [63:0] rs2);
        bus.valid_i    = 1'b1;
        bus.unit_i     = unit;
        bus.op_i       = op;
        bus.use_imm_i  = use_imm;
        bus.imm_i      = imm;
        bus.pc_i       = pc;
        bus.rs1_data_i = rs1;
        bus.rs2_data_i = rs2;
    endtask

    function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b);
        if (b == 64'd0) return '1;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
        return 64'($signed(a) / $signed(b));
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic run_muldiv(input string tag, input logic is_div, input logic [63:0] a,
                              input logic [63:0] b, input logic [63:0] exp, input int exp_cycles);
        int   cycles;
        logic done;
        cycles = 0;
        done   = 1'b0;
        drive(is_div ? 2'd2 : 2'd1, is_div ? 3'd3 : 3'd2, 1'b0, 64'd0, 64'h40, a, b);
        #1;
        check({tag, "_stall_issue"}, 64'(bus.stall_o), 64'd1);
        while (!done && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 1) begin
                bus.rs1_data_i = ~a;
                bus.rs2_data_i = a ^ b;
            end
            if (bus.muldiv_valid_o === 1'b1) done = 1'b1;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_cycles"}, 64'(cycles), 64'(exp_cycles));
        check({tag, "_result"}, bus.muldiv_result_o, exp);
        check({tag, "_stall_done"}, 64'(bus.stall_o), 64'd0);
        bus.valid_i = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_pulse_end"}, 64'(bus.muldiv_valid_o), 64'd0);
        check({tag, "_hold"}, bus.muldiv_result_o, exp);
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] prev;
        logic        seen;

        bus.kill_i       = 1'b0;
        bus.valid_i      = 1'b0;
        bus.unit_i       = 2'd0;
        bus.op_i         = 3'd0;
        bus.use_imm_i    = 1'b0;
        bus.imm_i        = '0;
        bus.pc_i         = '0;
        bus.rs1_data_i   = '0;
        bus.rs2_data_i   = '0;
        bus.pred_taken_i = 1'b0;
        bus.pred_addr_i  = '0;

        // reset state and combinational path during reset
        #2;
        check("rst_mdvalid", 64'(bus.muldiv_valid_o), 64'd0);
        check("rst_mdresult", bus.muldiv_result_o, 64'd0);
        check("rst_stall", 64'(bus.stall_o), 64'd0);
        drive(2'd0, 3'd0, 1'b0, 64'd0, 64'h100, '1, 64'd1);
        #1;
        check("rst_add_comb", bus.arith_result_o, 64'd0);
        check("rst_add_valid", 64'(bus.arith_valid_o), 64'd1);
        bus.valid_i = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // ADD / SUB
        drive(2'd0, 3'd0, 1'b0, 64'd0, 64'h100, '1, 64'd1);
        #1;
        check("add_wrap", bus.arith_result_o, 64'd0);
        check("add_valid", 64'(bus.arith_valid_o), 64'd1);
        check("add_res_pc", bus.arith_result_pc_o, 64'd0);
        check("add_taken", 64'(bus.branch_taken_o), 64'd0);
        check("add_target", bus.branch_target_o, 64'd0);
        check("add_correct", 64'(bus.correct_branch_pred_o), 64'd1);
        check("add_bpc", bus.branch_pc_o, 64'h100);
        check("add_stall", 64'(bus.stall_o), 64'd0);
        drive(2'd0, 3'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'h104, 64'd10, 64'd999);
        #1;
        check("add_imm", bus.arith_result_o, 64'd7);
        drive(2'd0, 3'd1, 1'b0, 64'd0, 64'h108, 64'd5, 64'd7);
        #1;
        check("sub_neg", bus.arith_result_o, 64'hFFFF_FFFF_FFFF_FFFE);
        bus.kill_i = 1'b1;
        #1;
        check("kill_arith_valid", 64'(bus.arith_valid_o), 64'd0);
        bus.kill_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            a = rnd64();
            b = rnd64();
            drive(2'd0, 3'd0, 1'b0, 64'd0, 64'h200, a, b);
            #1;
            check("add_rand", bus.arith_result_o, a + b);
            bus.op_i = 3'd1;
            #1;
            check("sub_rand", bus.arith_result_o, a - b);
        end
        bus.valid_i = 1'b0;
        #1;
        check("arith_idle_valid", 64'(bus.arith_valid_o), 64'd0);

        // JAL / JALR
        drive(2'd3, 3'd4, 1'b0, 64'h80, 64'h1000, 64'd0, 64'd0);
        #1;
        check("jal_result", bus.arith_result_o, 64'h1004);
        check("jal_res_pc", bus.arith_result_pc_o, 64'd0);
        check("jal_correct", 64'(bus.correct_branch_pred_o), 64'd1);
        check("jal_taken", 64'(bus.branch_taken_o), 64'd1);
        check("jal_valid", 64'(bus.arith_valid_o), 64'd1);
        drive(2'd3, 3'd5, 1'b0, 64'h10, 64'h2000, 64'h3001, 64'd0);
        bus.pred_taken_i = 1'b1;
        bus.pred_addr_i  = 64'h3010;
        #1;
        check("jalr_result", bus.arith_result_o, 64'h2004);
        check("jalr_res_pc", bus.arith_result_pc_o, 64'h3010);
        check("jalr_target", bus.branch_target_o, 64'h3010);
        check("jalr_taken", 64'(bus.branch_taken_o), 64'd1);
        check("jalr_bpc", bus.branch_pc_o, 64'h2000);
        check("jalr_correct", 64'(bus.correct_branch_pred_o), 64'd1);
        bus.pred_addr_i = 64'h3000;
        #1;
        check("jalr_wrong_addr", 64'(bus.correct_branch_pred_o), 64'd0);
        bus.pred_addr_i  = 64'h3010;
        bus.pred_taken_i = 1'b0;
        #1;
        check("jalr_not_pred", 64'(bus.correct_branch_pred_o), 64'd0);
        bus.valid_i = 1'b0;
        bus.pred_taken_i = 1'b0;
        @(posedge clk);
        #1;

        // MUL
        run_muldiv("mul_dir", 1'b0, 64'h1_0000_0000, 64'h1_0000_0003, 64'h3_0000_0000, 2);
        for (int i = 0; i < 20; i++) begin
            a = rnd64();
            b = rnd64();
            run_muldiv("mul_rand", 1'b0, a, b, a * b, 2);
        end

        // DIV
        run_muldiv("div_neg", 1'b1, -64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run_muldiv("div_zero", 1'b1, 64'd1234, 64'd0, '1, 65);
        run_muldiv("div_ovf", 1'b1, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 65);
        run_muldiv("div_exact", 1'b1, 64'd100, -64'd10, -64'd10, 65);
        for (int i = 0; i < 10; i++) begin
            a = rnd64();
            b = rnd64() >> $urandom_range(0, 62);
            if ($urandom_range(0, 1) == 1) b = -b;
            run_muldiv("div_rand", 1'b1, a, b, ref_div(a, b), 65);
        end

        // kill mid-DIV
        prev = bus.muldiv_result_o;
        drive(2'd2, 3'd3, 1'b0, 64'd0, 64'h300, -64'd7, 64'd2);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
        end
        #1;
        check("kill_pre_stall", 64'(bus.stall_o), 64'd1);
        bus.kill_i = 1'b1;
        #1;
        check("kill_stall", 64'(bus.stall_o), 64'd0);
        check("kill_mdvalid", 64'(bus.muldiv_valid_o), 64'd0);
        @(posedge clk);
        #1;
        bus.kill_i  = 1'b0;
        bus.valid_i = 1'b0;
        #1;
        check("kill_stall_after", 64'(bus.stall_o), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (bus.muldiv_valid_o === 1'b1) seen = 1'b1;
        end
        check("kill_no_pulse", 64'(seen), 64'd0);
        check("kill_result_kept", bus.muldiv_result_o, prev);
        run_muldiv("mul_after_kill", 1'b0, 64'd6, 64'd7, 64'd42, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
